// File: rtl/conv_buf_pkg.sv
// Shared types and helpers for the convolution input-set buffer.
package conv_buf_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } rbc_state_e;

  // One slot stays free so full and empty remain distinguishable.
  function automatic int unsigned rb_cap(input int unsigned buffer_size);
    return buffer_size - 1;
  endfunction

endpackage

// File: rtl/occupancy_counter.sv
// Saturating up/down occupancy counter; simultaneous inc and dec cancel.
module occupancy_counter #(
  parameter int unsigned MAX = 3,
  parameter int unsigned LW  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [LW-1:0] o_level
);

  logic [LW-1:0] r_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
    end else if (i_inc && !i_dec && (r_level < LW'(MAX))) begin
      r_level <= r_level + 1'b1;
    end else if (i_dec && !i_inc && (r_level != '0)) begin
      r_level <= r_level - 1'b1;
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/ring_buffer_ctrl.sv
// Tile sequencer for the input-set ring buffer: owns wen/ren strobes, occupancy
// and the per-tile set count; data bypasses this block.
module ring_buffer_ctrl
  import conv_buf_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic [CNT_W-1:0]             i_num_sets,
  output logic                         o_busy,
  output logic                         o_done,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  output logic                         o_buf_wen,
  output logic                         o_buf_ren,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [$clog2(BUFFER_SIZE):0] o_level
);

  localparam int unsigned LW  = $clog2(BUFFER_SIZE) + 1;
  localparam int unsigned CAP = rb_cap(BUFFER_SIZE);

  rbc_state_e       r_state;
  logic [CNT_W-1:0] r_num_sets;
  logic [CNT_W-1:0] r_wr_cnt;
  logic [CNT_W-1:0] r_rd_cnt;
  logic             r_out_valid;

  logic [LW-1:0]    w_level;
  logic             w_in_ready;
  logic             w_wen;
  logic             w_ren;
  logic             w_hs;
  logic             w_last_wr;
  logic             w_last_rd;

  assign w_in_ready = (r_state == StRun) && (w_level < LW'(CAP)) && (r_wr_cnt < r_num_sets);
  assign w_wen      = i_in_valid && w_in_ready;
  assign w_ren      = (w_level != '0) && (!r_out_valid || i_out_ready) &&
                      ((r_state == StRun) || (r_state == StDrain));
  assign w_hs       = r_out_valid && i_out_ready;
  // num_sets is non-zero whenever these are evaluated in RUN/DRAIN.
  assign w_last_wr  = w_wen && (r_wr_cnt == r_num_sets - 1'b1);
  assign w_last_rd  = w_hs && (r_rd_cnt == r_num_sets - 1'b1);

  occupancy_counter #(
    .MAX (CAP),
    .LW  (LW)
  ) u_occupancy (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_wen),
    .i_dec   (w_ren),
    .o_level (w_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_num_sets  <= '0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_wen) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_hs)  r_rd_cnt <= r_rd_cnt + 1'b1;

      if (w_ren) begin
        r_out_valid <= 1'b1;
      end else if (w_hs) begin
        r_out_valid <= 1'b0;
      end

      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            if (i_num_sets != '0) begin
              r_state    <= StRun;
              r_num_sets <= i_num_sets;
              r_wr_cnt   <= '0;
              r_rd_cnt   <= '0;
            end else begin
              r_state <= StDone;
            end
          end
        end
        StRun: begin
          if (w_last_wr) r_state <= StDrain;
        end
        StDrain: begin
          if (w_last_rd) r_state <= StDone;
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy      = (r_state != StIdle);
  assign o_done      = (r_state == StDone);
  assign o_in_ready  = w_in_ready;
  assign o_buf_wen   = w_wen;
  assign o_buf_ren   = w_ren;
  assign o_out_valid = r_out_valid;
  assign o_level     = w_level;

endmodule

// File: tb/tb_ring_buffer_ctrl.sv
// Bench for ring_buffer_ctrl: buffer model plus data scoreboard, table-driven
// tiles and hand-written corner sequences.
module tb_ring_buffer_ctrl;

  localparam int unsigned BS  = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned LW  = 3;
  localparam int unsigned CAP = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_start = 1'b0;
  logic [CW-1:0] i_num_sets = '0;
  logic          i_in_valid = 1'b0;
  logic          i_out_ready = 1'b0;
  logic          o_busy, o_done, o_in_ready, o_buf_wen, o_buf_ren, o_out_valid;
  logic [LW-1:0] o_level;

  ring_buffer_ctrl #(
    .BUFFER_SIZE (BS),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_num_sets  (i_num_sets),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .o_buf_wen   (o_buf_wen),
    .o_buf_ren   (o_buf_ren),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_level     (o_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int imode;  // 0 always valid, 1 random
    int omode;  // 0 always ready, 1 random, 2 held low
    int lat;    // start-to-done cycles, -1 when traffic is random
    int maxl;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] mem[BS];
  logic [31:0] dout, din;
  logic [31:0] q[$];
  int rp, wp, cyc, st, done_cyc;
  int n_wen, n_ren, n_hs, n_done, max_lvl, bad;
  int imode, omode;
  bit prev_hold;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic drive();
    i_in_valid  = (imode == 0) ? 1'b1 : 1'($urandom & 1);
    i_out_ready = (omode == 0) ? 1'b1 : (omode == 1) ? 1'($urandom & 1) : 1'b0;
  endtask

  task automatic model_reset();
    rp = 0; wp = 0; q.delete(); prev_hold = 0; dout = '0; din = $urandom;
  endtask

  // Sampled at negedge: protocol invariants, scoreboard, then buffer update.
  task automatic monitor();
    if (int'(o_level) > max_lvl) max_lvl = int'(o_level);
    if (o_buf_wen != (i_in_valid && o_in_ready)) bad++;
    if (o_buf_ren && o_out_valid && !i_out_ready) bad++;
    if (prev_hold && !o_out_valid) bad++;
    if (o_in_ready && int'(o_level) >= int'(CAP)) bad++;
    prev_hold = o_out_valid && !i_out_ready;
    if (o_out_valid && i_out_ready) begin
      n_hs++;
      if (q.size() == 0) chk("data_underflow", 1, 0);
      else chk("data_order", int'(dout), int'(q.pop_front()));
    end
    if (o_buf_ren) begin
      dout = mem[rp]; rp = (rp + 1) % BS; n_ren++;
    end
    if (o_buf_wen) begin
      mem[wp] = din; q.push_back(din); wp = (wp + 1) % BS; din = $urandom; n_wen++;
    end
    if (o_done) begin
      n_done++; done_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic begin_tile(input int n, input int im, input int om);
    imode = im; omode = om;
    n_wen = 0; n_ren = 0; n_hs = 0; n_done = 0; max_lvl = 0; bad = 0; done_cyc = -1;
    i_num_sets = CW'(n);
    i_start = 1'b1;
    drive();
    st = cyc;
    tick();
    i_start = 1'b0;
    chk("busy_after_start", int'(o_busy), 1);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      tick(); k++;
    end
    if (n_done == 0) chk("done_timeout", 0, 1);
    tick();
    tick();
  endtask

  task automatic end_checks(input string tag, input int n, input int lat, input int maxl);
    chk({tag, "_wen"}, n_wen, n);
    chk({tag, "_ren"}, n_ren, n);
    chk({tag, "_hs"}, n_hs, n);
    chk({tag, "_done_count"}, n_done, 1);
    chk({tag, "_queue_empty"}, q.size(), 0);
    if (lat >= 0) chk({tag, "_done_latency"}, done_cyc - st, lat);
    chk({tag, "_max_level_ok"}, int'(max_lvl <= maxl), 1);
    chk({tag, "_protocol_violations"}, bad, 0);
    chk({tag, "_idle_after"}, int'(o_busy), 0);
  endtask

  initial begin
    vecs[0] = '{n: 0,   imode: 0, omode: 0, lat: 1,  maxl: 0};
    vecs[1] = '{n: 1,   imode: 0, omode: 0, lat: 4,  maxl: 1};
    vecs[2] = '{n: 2,   imode: 0, omode: 0, lat: 5,  maxl: 1};
    vecs[3] = '{n: 10,  imode: 0, omode: 0, lat: 13, maxl: 1};
    vecs[4] = '{n: 7,   imode: 1, omode: 1, lat: -1, maxl: 3};
    vecs[5] = '{n: 200, imode: 1, omode: 1, lat: -1, maxl: 3};
    cyc = 0; imode = 0; omode = 0;
    model_reset();

    #1 rst = 1'b1;
    #2;
    chk("reset_outputs", int'({o_busy, o_done, o_in_ready, o_buf_wen, o_buf_ren, o_out_valid,
                               o_level}), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      begin_tile(vecs[i].n, vecs[i].imode, vecs[i].omode);
      wait_done(vecs[i].n * 10 + 50);
      end_checks($sformatf("vec%0d", i), vecs[i].n, vecs[i].lat, vecs[i].maxl);
    end

    // Backpressure: one set parks in the output register, three fill the ring.
    begin_tile(6, 0, 2);
    repeat (20) tick();
    chk("bp_writes", n_wen, 4);
    chk("bp_handshakes", n_hs, 0);
    chk("bp_in_ready", int'(o_in_ready), 0);
    chk("bp_level", int'(o_level), 3);
    chk("bp_out_valid", int'(o_out_valid), 1);
    omode = 0;
    wait_done(100);
    end_checks("bp", 6, -1, 3);

    // Reset in the middle of a 12-set tile, then a clean 4-set tile.
    begin_tile(12, 0, 0);
    for (int k = 0; k < 100 && n_hs < 5; k++) tick();
    chk("mid_reached_set5", n_hs, 5);
    rst = 1'b1;
    #1;
    chk("mid_reset_outputs", int'({o_busy, o_done, o_in_ready, o_buf_wen, o_buf_ren,
                                   o_out_valid, o_level}), 0);
    model_reset();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    begin_tile(4, 0, 0);
    wait_done(60);
    end_checks("post_reset", 4, 7, 1);

    // A start pulse during RUN must not retarget or restart the tile.
    begin_tile(5, 0, 0);
    repeat (2) tick();
    i_start = 1'b1;
    i_num_sets = CW'(9);
    tick();
    i_start = 1'b0;
    wait_done(60);
    end_checks("start_in_run", 5, 8, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
